hazard_bubble_ctrl: RTL and testbench

Parametrised hazard-control and bubble-insertion unit between the Control decoder and the ID/EX pipeline register. It detects load-use hazards, squashes the decoded control bundle for a configurable number of bubble cycles, freezes PC and IF/ID while bubbling, and arbitrates against data-cache miss stalls and branch flushes. It replaces the fixed six-signal control mux with a generic-width, multi-cycle, reset-safe block.

---
 rtl/hazard_bubble_ctrl.sv | 122 ++++++++++++
 tb/tb_hazard_bubble_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/hazard_bubble_ctrl.sv
// Load-use hazard detector and bubble inserter between Control and ID/EX.
// Optional perf counters (bubble_cnt_o, memstall_cnt_o) are built when HAZARD_PERF_EN is defined.
module hazard_bubble_ctrl #(
  parameter int                CTRL_W     = 8,
  parameter logic [CTRL_W-1:0] BUBBLE_VAL = {CTRL_W{1'b0}},
  parameter int                LOAD_LAT   = 1,
  parameter int                REG_AW     = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              ex_memread_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              mem_stall_i,
  input  logic              flush_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic              pipe_stall_o,
  output logic              bubble_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       bubble_cnt_o,
  output logic [31:0]       memstall_cnt_o
`endif
);

  localparam int CNT_W = $clog2(LOAD_LAT + 1);

  typedef enum logic [0:0] {RUN = 1'b0, BUBBLE = 1'b1} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             hz;

  assign hz = ex_memread_i & (ex_rd_i != {REG_AW{1'b0}}) &
              ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i));

  // State and remaining-bubble counter
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= RUN;
      cnt   <= {CNT_W{1'b0}};
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: a data-cache stall freezes the FSM without consuming count
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!mem_stall_i) begin
      case (state)
        RUN: begin
          if (hz && (LOAD_LAT > 1)) begin
            state_nxt = BUBBLE;
            cnt_nxt   = CNT_W'(LOAD_LAT - 1);
          end else begin
            state_nxt = RUN;
          end
        end
        BUBBLE: begin
          cnt_nxt = cnt - CNT_W'(1);
          if (cnt <= CNT_W'(1)) begin
            state_nxt = RUN;
          end else begin
            state_nxt = BUBBLE;
          end
        end
        default: begin
          state_nxt = RUN;
          cnt_nxt   = {CNT_W{1'b0}};
        end
      endcase
    end else begin
      state_nxt = state;
    end
  end

  // Outputs: reset forces the safe bundle, stall outranks bubble, bubble outranks flush
  always_comb begin
    ctrl_o       = BUBBLE_VAL;
    pc_write_o   = 1'b0;
    ifid_write_o = 1'b0;
    ifid_flush_o = 1'b0;
    pipe_stall_o = 1'b0;
    bubble_o     = 1'b0;
    if (!rst_i) begin
      ctrl_o = BUBBLE_VAL;
    end else if (mem_stall_i) begin
      ctrl_o       = ctrl_i;
      pipe_stall_o = 1'b1;
    end else begin
      bubble_o     = (state == BUBBLE) | hz;
      ctrl_o       = bubble_o ? BUBBLE_VAL : ctrl_i;
      pc_write_o   = ~bubble_o;
      ifid_write_o = ~bubble_o;
      ifid_flush_o = flush_i & ~bubble_o;
    end
  end

`ifdef HAZARD_PERF_EN
  // Free-running wrap-around event counters
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bubble_cnt_o   <= 32'd0;
      memstall_cnt_o <= 32'd0;
    end else begin
      bubble_cnt_o   <= bubble_cnt_o + {31'd0, bubble_o};
      memstall_cnt_o <= memstall_cnt_o + {31'd0, mem_stall_i};
    end
  end
`endif

endmodule

// File: tb/tb_hazard_bubble_ctrl.sv
// Scoreboard bench: two DUTs (LOAD_LAT 1 and 3) on shared stimulus, checked against a
// remaining-bubble-count reference model.
module tb_hazard_bubble_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] ctrl = 8'hFF;
  logic [4:0] rs1 = 5'd0, rs2 = 5'd0, rd = 5'd0;
  logic       memread = 1'b0, stall = 1'b0, flush = 1'b0;

  logic [7:0] c_o [2];
  logic       pcw [2], ifw [2], ifl [2], pst [2], bub [2];
  logic [31:0] bc [2], mc [2];

  typedef struct packed {
    logic [7:0]  ctrl;
    logic        pc, ifw, ifl, pst, bub;
    logic [31:0] bc, mc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   rem [2] = '{0, 0};
  logic [31:0] bcm [2] = '{32'd0, 32'd0};
  logic [31:0] mcm [2] = '{32'd0, 32'd0};
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  hazard_bubble_ctrl #(.LOAD_LAT(1)) u1 (
    .clk_i(clk), .rst_i(rst), .ctrl_i(ctrl), .id_rs1_i(rs1), .id_rs2_i(rs2),
    .ex_memread_i(memread), .ex_rd_i(rd), .mem_stall_i(stall), .flush_i(flush),
    .ctrl_o(c_o[0]), .pc_write_o(pcw[0]), .ifid_write_o(ifw[0]), .ifid_flush_o(ifl[0]),
    .pipe_stall_o(pst[0]), .bubble_o(bub[0])
`ifdef HAZARD_PERF_EN
    , .bubble_cnt_o(bc[0]), .memstall_cnt_o(mc[0])
`endif
  );

  hazard_bubble_ctrl #(.LOAD_LAT(3)) u3 (
    .clk_i(clk), .rst_i(rst), .ctrl_i(ctrl), .id_rs1_i(rs1), .id_rs2_i(rs2),
    .ex_memread_i(memread), .ex_rd_i(rd), .mem_stall_i(stall), .flush_i(flush),
    .ctrl_o(c_o[1]), .pc_write_o(pcw[1]), .ifid_write_o(ifw[1]), .ifid_flush_o(ifl[1]),
    .pipe_stall_o(pst[1]), .bubble_o(bub[1])
`ifdef HAZARD_PERF_EN
    , .bubble_cnt_o(bc[1]), .memstall_cnt_o(mc[1])
`endif
  );

  // Reference model: remaining bubble cycles per instance; also updates the model state.
  task automatic model(input int k, input int lat, output exp_t e);
    logic hz;
    hz = memread && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
    e = '0;
    if (!rst) begin
      rem[k] = 0;
      bcm[k] = 32'd0;
      mcm[k] = 32'd0;
    end else begin
      e.bc = bcm[k];
      e.mc = mcm[k];
      if (stall) begin
        e.ctrl = ctrl;
        e.pst  = 1'b1;
        mcm[k] = mcm[k] + 32'd1;
      end else begin
        e.bub  = (rem[k] > 0) || hz;
        e.ctrl = e.bub ? 8'h00 : ctrl;
        e.pc   = !e.bub;
        e.ifw  = !e.bub;
        e.ifl  = flush && !e.bub;
        if (rem[k] > 0) rem[k] = rem[k] - 1;
        else if (hz) rem[k] = lat - 1;
        if (e.bub) bcm[k] = bcm[k] + 32'd1;
      end
    end
  endtask

  task automatic step(input logic [7:0] c, input logic [4:0] r1, input logic [4:0] r2,
                      input logic mr, input logic [4:0] d, input logic st,
                      input logic fl, input logic rs);
    exp_t e;
    @(negedge clk);
    ctrl = c; rs1 = r1; rs2 = r2; memread = mr; rd = d; stall = st; flush = fl; rst = rs;
    model(0, 1, e); q0.push_back(e);
    model(1, 3, e); q1.push_back(e);
  endtask

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s (LOAD_LAT=%0d) at %0t: got %h expected %h", name,
               (k == 0) ? 1 : 3, $time, act, exp);
    else
      passed++;
  endtask

  // Monitor: sample combinational outputs 2ns after stimulus, well before the rising edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      for (int k = 0; k < 2; k++) begin
        if ((k == 0) ? (q0.size() != 0) : (q1.size() != 0)) begin
          e = (k == 0) ? q0.pop_front() : q1.pop_front();
          check("ctrl_o", k, {24'd0, c_o[k]}, {24'd0, e.ctrl});
          check("pc_write_o", k, {31'd0, pcw[k]}, {31'd0, e.pc});
          check("ifid_write_o", k, {31'd0, ifw[k]}, {31'd0, e.ifw});
          check("ifid_flush_o", k, {31'd0, ifl[k]}, {31'd0, e.ifl});
          check("pipe_stall_o", k, {31'd0, pst[k]}, {31'd0, e.pst});
          check("bubble_o", k, {31'd0, bub[k]}, {31'd0, e.bub});
`ifdef HAZARD_PERF_EN
          check("bubble_cnt_o", k, bc[k], e.bc);
          check("memstall_cnt_o", k, mc[k], e.mc);
`endif
        end
      end
    end
  end

  initial begin
    int guard;
`ifndef HAZARD_PERF_EN
    bc = '{32'd0, 32'd0};
    mc = '{32'd0, 32'd0};
`endif
    // reset held 3 cycles, then pass-through
    repeat (3) step(8'hFF, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step(8'hFF, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    // single-cycle load-use pulse on rs2
    step(8'hA5, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
    repeat (3) step(8'h3C, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    // x0 never hazards
    step(8'h11, 5'd0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    // stall interleaved inside the bubble
    step(8'h22, 5'd4, 5'd1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1);
    repeat (2) step(8'h33, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    repeat (3) step(8'h44, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    // hazard together with stall: stall wins, bubble starts when stall drops
    step(8'h55, 5'd6, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1);
    step(8'h55, 5'd6, 5'd1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b1);
    repeat (3) step(8'h66, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    // flush against hazard, then plain flush
    step(8'h77, 5'd7, 5'd2, 1'b1, 5'd7, 1'b0, 1'b1, 1'b1);
    repeat (2) step(8'h78, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    step(8'h79, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    // reset in the second bubble cycle
    step(8'h88, 5'd3, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1);
    step(8'h99, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) step(8'h9A, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    // randomized traffic with a small register space to provoke hazards
    for (int i = 0; i < 600; i++)
      step(8'($urandom_range(0, 255)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 49) != 0));
    guard = 0;
    while (((q0.size() != 0) || (q1.size() != 0)) && (guard < 10)) begin
      @(negedge clk);
      guard++;
    end
    #3;
    if ((q0.size() != 0) || (q1.size() != 0)) begin
      total++;
      $display("FAIL drain: %0d/%0d entries left, expected 0/0", q0.size(), q1.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
